// File: rtl/nes_pixel_colorizer_pkg.sv
// +----------------------------------------------------------------------------+
// | nes_color_pkg                                                              |
// | NES system palette (6-bit index -> 12-bit RGB) and pixel-field constants.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package nes_color_pkg;

    localparam int PIX_BITS_W  = 2;
    localparam int PIX_PAL_W   = 2;
    localparam int PAL_ADDR_W  = 5;
    localparam int PAL_DATA_W  = 8;
    localparam int COLOR_IDX_W = 6;
    localparam int RGB12_W     = 12;

    localparam logic [PAL_ADDR_W-1:0] BACKDROP_ADDR = 5'd0;
    localparam logic [RGB12_W-1:0]    RGB_BLACK     = 12'h000;

    // Index order 0x00..0x3F; rows are one luma group of 16 hues.
    localparam logic [RGB12_W-1:0] NES_PALETTE [0:63] = '{
        12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
        12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
        12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
        12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
        12'hFFF, 12'h3BF, 12'h59F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
        12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
        12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
        12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
    };

endpackage

`default_nettype wire

// File: rtl/nes_pixel_colorizer_if.sv
// +----------------------------------------------------------------------------+
// | nes_pixel_colorizer_if                                                     |
// | Pixel-in, palette-memory and RGB-out signals of the colorizer.             |
// | Optional macro: PIXEL_GRAYSCALE_EN adds the gray input.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface nes_pixel_colorizer_if
    import nes_color_pkg::*;
#(
    parameter int SB_W  = 2,
    parameter int RGB_W = 12
);
    logic                  pix_valid;
    logic [PIX_BITS_W-1:0] pix_bits;
    logic [PIX_PAL_W-1:0]  pix_pal;
    logic                  pix_spr;
    logic                  pix_blank;
    logic [SB_W-1:0]       pix_sb;
`ifdef PIXEL_GRAYSCALE_EN
    logic                  gray;
`endif
    logic [PAL_ADDR_W-1:0] pal_addr;
    logic [PAL_DATA_W-1:0] pal_dout;
    logic                  rgb_valid;
    logic [RGB_W-1:0]      rgb;
    logic [SB_W-1:0]       rgb_sb;

    modport master (
        output pix_valid, pix_bits, pix_pal, pix_spr, pix_blank, pix_sb,
`ifdef PIXEL_GRAYSCALE_EN
        output gray,
`endif
        output pal_dout,
        input  pal_addr, rgb_valid, rgb, rgb_sb
    );

    modport slave (
        input  pix_valid, pix_bits, pix_pal, pix_spr, pix_blank, pix_sb,
`ifdef PIXEL_GRAYSCALE_EN
        input  gray,
`endif
        input  pal_dout,
        output pal_addr, rgb_valid, rgb, rgb_sb
    );

endinterface

`default_nettype wire

// File: rtl/nes_sys_palette.sv
// +----------------------------------------------------------------------------+
// | nes_sys_palette                                                            |
// | Registered 64x12 system-palette lookup with load enable and black force.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module nes_sys_palette
    import nes_color_pkg::*;
(
    input  wire logic                   clk,
    input  wire logic                   en_i,
    input  wire logic                   black_i,
    input  wire logic [COLOR_IDX_W-1:0] idx_i,
    output logic      [RGB12_W-1:0]     rgb_o
);

    logic [RGB12_W-1:0] rgb_q;
    logic [RGB12_W-1:0] rgb_d;

    always_comb begin
        rgb_d = rgb_q;
        if (en_i) begin
            rgb_d = black_i ? RGB_BLACK : NES_PALETTE[idx_i];
        end
    end

    always_ff @(posedge clk) begin
        rgb_q <= rgb_d;
    end

    assign rgb_o = rgb_q;

endmodule

`default_nettype wire

// File: rtl/nes_pixel_colorizer.sv
// +----------------------------------------------------------------------------+
// | nes_pixel_colorizer                                                        |
// | Palette address generation, 2-cycle colour pipeline to 12-bit RGB.        |
// | Optional macro: PIXEL_GRAYSCALE_EN (gray flag masks index to 0x30).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module nes_pixel_colorizer
    import nes_color_pkg::*;
#(
    parameter int RGB_W = 12,
    parameter int SB_W  = 2
)(
    input  wire logic             clk,
    input  wire logic             rst,
    nes_pixel_colorizer_if.slave  bus_if
);

    generate
        if (RGB_W != RGB12_W) begin : g_rgb_w_unsupported
            $error("nes_pixel_colorizer: only RGB_W=12 is supported");
        end
    endgenerate

    logic                   s1_valid_q;
    logic                   s1_blank_q;
    logic [SB_W-1:0]        s1_sb_q;
    logic                   s1_gray_q;
    logic                   rgb_valid_q;
    logic [SB_W-1:0]        rgb_sb_q;

    logic [PAL_ADDR_W-1:0]  w_pal_addr;
    logic [COLOR_IDX_W-1:0] w_color_idx;
    logic [RGB12_W-1:0]     w_rgb;
    logic                   w_gray_in;
    logic                   w_unused_pal_hi;

`ifdef PIXEL_GRAYSCALE_EN
    assign w_gray_in = bus_if.gray;
`else
    assign w_gray_in = 1'b0;
`endif

    // Transparent pixels of either layer fall through to the shared backdrop.
    always_comb begin
        w_pal_addr = BACKDROP_ADDR;
        if (!rst && (bus_if.pix_bits != '0)) begin
            w_pal_addr = {bus_if.pix_spr, bus_if.pix_pal, bus_if.pix_bits};
        end
    end

    assign bus_if.pal_addr = w_pal_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_blank_q <= 1'b0;
            s1_sb_q    <= '0;
            s1_gray_q  <= 1'b0;
        end else begin
            s1_valid_q <= bus_if.pix_valid;
            s1_blank_q <= bus_if.pix_blank;
            s1_sb_q    <= bus_if.pix_sb;
            s1_gray_q  <= w_gray_in;
        end
    end

    // Grayscale keeps only the luma row of the index.
    assign w_color_idx = bus_if.pal_dout[COLOR_IDX_W-1:0] &
                         (s1_gray_q ? 6'h30 : 6'h3F);
    assign w_unused_pal_hi = ^bus_if.pal_dout[PAL_DATA_W-1:COLOR_IDX_W];

    // Reset loads black through the lookup register, which has no reset of its own.
    nes_sys_palette u_sys_palette (
        .clk     (clk),
        .en_i    (rst | s1_valid_q),
        .black_i (rst | s1_blank_q),
        .idx_i   (w_color_idx),
        .rgb_o   (w_rgb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_valid_q <= 1'b0;
            rgb_sb_q    <= '0;
        end else begin
            rgb_valid_q <= s1_valid_q;
            rgb_sb_q    <= s1_sb_q;
        end
    end

    assign bus_if.rgb_valid = rgb_valid_q;
    assign bus_if.rgb       = w_rgb;
    assign bus_if.rgb_sb    = rgb_sb_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_pixel_colorizer.sv
// +----------------------------------------------------------------------------+
// | tb_nes_pixel_colorizer                                                     |
// | Table-driven bench with a registered 32x8 palette memory model.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_nes_pixel_colorizer;

    logic clk;
    logic rst;
    logic [7:0] pal_mem [0:31];
    int n_pass;
    int n_total;

    nes_pixel_colorizer_if #(.SB_W(2), .RGB_W(12)) bus_if ();

    nes_pixel_colorizer #(.RGB_W(12), .SB_W(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        bus_if.pal_dout <= pal_mem[bus_if.pal_addr];
    end

    typedef struct {
        logic        v;
        logic [1:0]  b;
        logic [1:0]  p;
        logic        s;
        logic        bl;
        logic [1:0]  sb;
        logic [4:0]  addr;
        logic        ov;
        logic [11:0] orgb;
        logic [1:0]  osb;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] b, input logic [1:0] p,
                         input logic s, input logic bl, input logic [1:0] sb);
        bus_if.pix_valid = v;
        bus_if.pix_bits  = b;
        bus_if.pix_pal   = p;
        bus_if.pix_spr   = s;
        bus_if.pix_blank = bl;
        bus_if.pix_sb    = sb;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [11:0] orgb,
                             input logic [1:0] osb);
        check({tag, " rgb_valid"}, {31'd0, bus_if.rgb_valid}, {31'd0, ov});
        check({tag, " rgb"}, {20'd0, bus_if.rgb}, {20'd0, orgb});
        check({tag, " rgb_sb"}, {30'd0, bus_if.rgb_sb}, {30'd0, osb});
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 32; i++) pal_mem[i] = 8'h3F;
        pal_mem[0]     = 8'h22;
        pal_mem[1]     = 8'h29;
        pal_mem[3]     = 8'h0F;
        pal_mem[5]     = 8'h01;
        pal_mem[10]    = 8'h16;
        pal_mem[5'h16] = 8'h30;
        pal_mem[31]    = 8'hC2;

        //         v  b     p     s  bl sb    addr   ov  orgb     osb
        tbl[0]  = '{1, 2'd1, 2'd0, 0, 0, 2'd0, 5'd1,  0, 12'h000, 2'd0};
        tbl[1]  = '{1, 2'd0, 2'd3, 1, 0, 2'd1, 5'd0,  0, 12'h000, 2'd0};
        tbl[2]  = '{1, 2'd2, 2'd1, 1, 0, 2'd2, 5'd22, 1, 12'hBF1, 2'd0};
        tbl[3]  = '{1, 2'd3, 2'd0, 0, 0, 2'd3, 5'd3,  1, 12'h59F, 2'd1};
        tbl[4]  = '{1, 2'd1, 2'd1, 0, 0, 2'd0, 5'd5,  1, 12'hFFF, 2'd2};
        tbl[5]  = '{1, 2'd3, 2'd3, 1, 0, 2'd1, 5'd31, 1, 12'h000, 2'd3};
        tbl[6]  = '{1, 2'd2, 2'd2, 0, 0, 2'd2, 5'd10, 1, 12'h00F, 2'd0};
        tbl[7]  = '{1, 2'd1, 2'd0, 0, 0, 2'd3, 5'd1,  1, 12'h00B, 2'd1};
        tbl[8]  = '{1, 2'd1, 2'd0, 0, 1, 2'd0, 5'd1,  1, 12'hF30, 2'd2};
        tbl[9]  = '{0, 2'd2, 2'd1, 1, 0, 2'd1, 5'd22, 1, 12'hBF1, 2'd3};
        tbl[10] = '{0, 2'd0, 2'd0, 0, 0, 2'd2, 5'd0,  1, 12'h000, 2'd0};
        tbl[11] = '{1, 2'd1, 2'd1, 0, 0, 2'd3, 5'd5,  0, 12'h000, 2'd1};
        tbl[12] = '{0, 2'd0, 2'd0, 0, 0, 2'd0, 5'd0,  0, 12'h000, 2'd2};
        tbl[13] = '{0, 2'd0, 2'd0, 0, 0, 2'd0, 5'd0,  1, 12'h00F, 2'd3};
        tbl[14] = '{0, 2'd0, 2'd0, 0, 0, 2'd0, 5'd0,  0, 12'h00F, 2'd0};
        tbl[15] = '{0, 2'd0, 2'd0, 0, 0, 2'd0, 5'd0,  0, 12'h00F, 2'd0};

        rst = 1'b1;
        drive(1'b1, 2'd3, 2'd2, 1'b1, 1'b0, 2'd3);
`ifdef PIXEL_GRAYSCALE_EN
        bus_if.gray = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_out("reset", 1'b0, 12'h000, 2'd0);
        check("reset pal_addr", {27'd0, bus_if.pal_addr}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst = 1'b0;
            check_out($sformatf("row%0d", i), tbl[i].ov, tbl[i].orgb, tbl[i].osb);
            drive(tbl[i].v, tbl[i].b, tbl[i].p, tbl[i].s, tbl[i].bl, tbl[i].sb);
            #1;
            check($sformatf("row%0d pal_addr", i), {27'd0, bus_if.pal_addr}, {27'd0, tbl[i].addr});
        end

        // Two pixels in flight when a one-cycle reset hits: both are dropped.
        @(negedge clk);
        drive(1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 2'd1);
        @(negedge clk);
        drive(1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 2'd2);
        rst = 1'b1;
        #1;
        check("midrst pal_addr", {27'd0, bus_if.pal_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_out("midrst t2", 1'b0, 12'h000, 2'd0);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        check("midrst t3 rgb_valid", {31'd0, bus_if.rgb_valid}, 32'd0);
        @(negedge clk);
        check("midrst t4 rgb_valid", {31'd0, bus_if.rgb_valid}, 32'd0);
        drive(1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 2'd3);
        @(negedge clk);
        check("midrst t5 rgb_valid", {31'd0, bus_if.rgb_valid}, 32'd0);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        check_out("midrst t6", 1'b1, 12'h00F, 2'd3);

`ifdef PIXEL_GRAYSCALE_EN
        // Index 0x29 with gray -> 0x20; index 0x16 with gray -> 0x10.
        drive(1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 2'd1);
        bus_if.gray = 1'b1;
        @(negedge clk);
        drive(1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 2'd2);
        @(negedge clk);
        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        bus_if.gray = 1'b0;
        check_out("gray 0x29", 1'b1, 12'hFFF, 2'd1);
        @(negedge clk);
        check_out("gray 0x16", 1'b1, 12'hBBB, 2'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nes_pixel_colorizer.md
Name: nes_pixel_colorizer

Overview:
- Sits directly downstream of the NES 32-entry palette memory (5-bit address, 8-bit data, registered read, 1-cycle latency).
- Takes the per-pixel stream from the background/sprite mux: 2 pattern bits, a 2-bit palette select and a sprite flag.
- Drives the palette memory address, consumes its data one cycle later, and maps the 6-bit NES colour index to 12-bit RGB for the VGA output stage.
- Pipelines valid/blank/sync sideband so they stay aligned with colour.

Parameters:
- RGB_W, 12, output RGB width (4:4:4); only 12 is supported.
- SB_W, 2, sideband width (hsync, vsync) carried alongside pixels.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pix_valid  in  1  pixel inputs valid this cycle.
- pix_bits  in  2  pattern-table colour bits (0 = transparent).
- pix_pal  in  2  palette select within table.
- pix_spr  in  1  1 = sprite palette (addresses 16..31), 0 = background.
- pix_blank  in  1  blanking: output black regardless of colour.
- pix_sb  in  SB_W  sync sideband.
- pal_addr  out  5  palette memory address.
- pal_dout  in  8  palette memory data, valid 1 cycle after pal_addr.
- rgb_valid  out  1  rgb output valid.
- rgb  out  RGB_W  {R[3:0],G[3:0],B[3:0]}.
- rgb_sb  out  SB_W  sideband aligned to rgb.

Behaviour:
- Reset values: rgb_valid=0, rgb=0, rgb_sb=0, pal_addr=0. All pipeline valid/blank flags are cleared.
- Address, combinational from inputs: pix_bits==0 gives pal_addr=5'd0 (universal backdrop, including sprites). Otherwise pal_addr={pix_spr,pix_pal,pix_bits}.
- S1 (cycle N+1): register valid, blank and sb into stage-1; pal_dout arrives this cycle. Take the colour index as pal_dout[5:0]; bits [7:6] are ignored.
- S2 (cycle N+2): register the RGB lookup of the index into rgb. Register rgb_valid and rgb_sb from stage-1. Total latency is 2 cycles from input to output.
- Blank: if the stage-1 blank flag is set, rgb=12'h000 at S2; sideband still passes through.
- Invalid pixels: if pix_valid=0, the pipeline still advances. rgb_valid=0 in the matching output cycle; rgb holds its previous value. pal_addr keeps tracking the inputs.
- No back-pressure: one pixel per cycle, full throughput. Back-to-back pixels produce back-to-back outputs.
- Indices 0x0D–0x0F, 0x1D–0x1F, 0x2E–0x2F and 0x3E–0x3F map to 12'h000 per the package table.
- Reset mid-stream: in-flight pixels are dropped. rgb_valid is 0 in the cycle after rst and on the following cycle if no new valid input arrives.

Optional Feature:
- Macro: PIXEL_GRAYSCALE_EN.
- When defined, adds input port gray (1 bit), sampled with pix_valid and pipelined to S1. At S1, a set gray flag replaces the colour index with index & 6'h30 before lookup (PPUMASK bit-0 semantics).
- When undefined, the port is absent and the index is used unmodified.

Decomposition:
- Package nes_color_pkg holds:
  - the 64-entry NES system-palette constant (6-bit index to 12-bit RGB);
  - the BACKDROP_ADDR=5'd0 constant;
  - the RGB black constant;
  - pixel-field width constants.
- Sub-module nes_sys_palette: registered 64x12 lookup, 1-cycle, clk only. It forms stage S2.

Test Plan:
- Palette loaded with the backdrop table shown in the smario dump (entry 0=0x22, 1=0x29, 3=0x0F, 0x16=0x30). Input bits=1, pal=0, spr=0, valid=1 at cycle N → pal_addr=1 in cycle N; rgb=LUT[0x29], rgb_valid=1 at N+2.
- bits=0, pal=3, spr=1 → pal_addr=0; rgb=LUT[0x22]=12'h59F at N+2.
- bits=2, pal=1, spr=1 → pal_addr=22; index 0x30 → rgb=12'hFFF. bits=3, pal=0, spr=0 → index 0x0F → rgb=12'h000.
- Stream of 8 consecutive valid pixels, sb toggling → 8 consecutive rgb_valid cycles, order preserved, rgb_sb delayed exactly 2 cycles.
- pix_blank=1 with bits=1 → rgb=12'h000, rgb_valid=1. A valid gap in the input → a rgb_valid=0 gap 2 cycles later.
- rst asserted for 1 cycle with 2 pixels in flight → both dropped; rgb_valid=0 until 2 cycles after the next valid input. With PIXEL_GRAYSCALE_EN: index 0x29 plus gray=1 → LUT[0x20].
